// File: rtl/rpn_wnn_repo_to_network_bridge_merger.sv
// Round-robin, packet-atomic 3:1 AXIS merger toward the network bridge.
// Ports: i_clk/i_ap_rst_n, three slave AXIS sources, one AXIS master.
module rpn_wnn_repo_to_network_bridge_merger #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = 64,
  parameter int AXIS_TDEST_WIDTH = 8,
  parameter int AXIS_TUSER_WIDTH = 64
) (
  input  logic                        i_clk,
  input  logic                        i_ap_rst_n,

  input  logic                        from_rpn_WNN_outgoing_repo_tvalid,
  output logic                        from_rpn_WNN_outgoing_repo_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_rpn_WNN_outgoing_repo_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_rpn_WNN_outgoing_repo_tkeep,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_rpn_WNN_outgoing_repo_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_rpn_WNN_outgoing_repo_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_rpn_WNN_outgoing_repo_tuser,
  input  logic                        from_rpn_WNN_outgoing_repo_tlast,

  input  logic                        from_rpn_WNN_incoming_repo_tvalid,
  output logic                        from_rpn_WNN_incoming_repo_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_rpn_WNN_incoming_repo_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_rpn_WNN_incoming_repo_tkeep,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_rpn_WNN_incoming_repo_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_rpn_WNN_incoming_repo_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_rpn_WNN_incoming_repo_tuser,
  input  logic                        from_rpn_WNN_incoming_repo_tlast,

  input  logic                        from_rpn_WAN_seq_num_initializer_tvalid,
  output logic                        from_rpn_WAN_seq_num_initializer_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_rpn_WAN_seq_num_initializer_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_rpn_WAN_seq_num_initializer_tkeep,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_rpn_WAN_seq_num_initializer_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_rpn_WAN_seq_num_initializer_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_rpn_WAN_seq_num_initializer_tuser,
  input  logic                        from_rpn_WAN_seq_num_initializer_tlast,

  output logic                        to_network_bridge_tvalid,
  input  logic                        to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_network_bridge_tkeep,
  output logic [AXIS_TDEST_WIDTH-1:0] to_network_bridge_tid,
  output logic [AXIS_TDEST_WIDTH-1:0] to_network_bridge_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                        to_network_bridge_tlast
);

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]  data;
    logic [AXIS_KEEP_WIDTH-1:0]  keep;
    logic [AXIS_TDEST_WIDTH-1:0] id;
    logic [AXIS_TDEST_WIDTH-1:0] dest;
    logic [AXIS_TUSER_WIDTH-1:0] user;
    logic                        last;
  } beat_t;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [2:0] vld;
  beat_t      beat [3];

  assign vld = {from_rpn_WAN_seq_num_initializer_tvalid,
                from_rpn_WNN_incoming_repo_tvalid,
                from_rpn_WNN_outgoing_repo_tvalid};

  assign beat[0] = {from_rpn_WNN_outgoing_repo_tdata,
                    from_rpn_WNN_outgoing_repo_tkeep,
                    from_rpn_WNN_outgoing_repo_tid,
                    from_rpn_WNN_outgoing_repo_tdest,
                    from_rpn_WNN_outgoing_repo_tuser,
                    from_rpn_WNN_outgoing_repo_tlast};
  assign beat[1] = {from_rpn_WNN_incoming_repo_tdata,
                    from_rpn_WNN_incoming_repo_tkeep,
                    from_rpn_WNN_incoming_repo_tid,
                    from_rpn_WNN_incoming_repo_tdest,
                    from_rpn_WNN_incoming_repo_tuser,
                    from_rpn_WNN_incoming_repo_tlast};
  assign beat[2] = {from_rpn_WAN_seq_num_initializer_tdata,
                    from_rpn_WAN_seq_num_initializer_tkeep,
                    from_rpn_WAN_seq_num_initializer_tid,
                    from_rpn_WAN_seq_num_initializer_tdest,
                    from_rpn_WAN_seq_num_initializer_tuser,
                    from_rpn_WAN_seq_num_initializer_tlast};

  state_t     state, state_d;
  logic [1:0] grant, grant_d;
  logic [1:0] ptr, ptr_d;
  logic [1:0] sel;
  logic [2:0] rdy;
  logic       slot_free;
  logic       xfer;
  beat_t      out_q;
  logic       out_vld;

  assign slot_free = !out_vld || to_network_bridge_tready;
  assign xfer      = (state == GRANT) && vld[grant] && slot_free;

  // Round-robin scan: ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    sel = inc3(inc3(ptr));
    if (vld[ptr])
      sel = ptr;
    else if (vld[inc3(ptr)])
      sel = inc3(ptr);
  end

  always_comb begin
    rdy = '0;
    if (state == GRANT) begin
      unique case (1'b1)
        (grant == 2'd0): rdy[0] = slot_free;
        (grant == 2'd1): rdy[1] = slot_free;
        default:         rdy[2] = slot_free;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    unique case (state)
      IDLE: begin
        if (|vld) begin
          grant_d = sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer && beat[grant].last) begin
          state_d = IDLE;
          ptr_d   = inc3(grant);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state <= IDLE;
      grant <= 2'd0;
      ptr   <= 2'd0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      ptr   <= ptr_d;
    end
  end

  // Single output slot; a new beat may load in the same cycle the
  // previous one is accepted, giving 1 beat/cycle within a packet.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (xfer) begin
      out_q   <= beat[grant];
      out_vld <= 1'b1;
    end else if (to_network_bridge_tready) begin
      out_vld <= 1'b0;
    end
  end

  assign from_rpn_WNN_outgoing_repo_tready       = rdy[0];
  assign from_rpn_WNN_incoming_repo_tready       = rdy[1];
  assign from_rpn_WAN_seq_num_initializer_tready = rdy[2];

  assign to_network_bridge_tvalid = out_vld;
  assign to_network_bridge_tdata  = out_q.data;
  assign to_network_bridge_tkeep  = out_q.keep;
  assign to_network_bridge_tid    = out_q.id;
  assign to_network_bridge_tdest  = out_q.dest;
  assign to_network_bridge_tuser  = out_q.user;
  assign to_network_bridge_tlast  = out_q.last;

endmodule
